icache_dm: RTL

Direct-mapped, read-only instruction cache sitting directly upstream of the rv32im core's fetch port. It serves the core's `icache_req`/`icache_addr` requests and returns `icache_rdata` with `icache_ready`. Misses are refilled line-by-line from a single-beat backing-memory read port. It supports whole-cache invalidation for `fence.i` and program reload.

---
 rtl/core_pkg.sv | 21 ++
 rtl/icache_data_ram.sv | 23 ++
 rtl/icache_dm.sv | 135 +++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared FSM encoding and cache address-split width helpers
package core_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOOKUP  = 2'd1,
    REFILL  = 2'd2,
    RESPOND = 2'd3
  } icache_state_t;

  function automatic int off_w(input int words_per_line);
    return $clog2(words_per_line) + 2;
  endfunction

  function automatic int idx_w(input int n_lines);
    return $clog2(n_lines);
  endfunction

  function automatic int tag_w(input int addr_width, input int n_lines, input int words_per_line);
    return addr_width - idx_w(n_lines) - off_w(words_per_line);
  endfunction
endpackage

// File: rtl/icache_data_ram.sv
// icache_data_ram: N_LINES x WORDS_PER_LINE x 32 word store, one write port, async read
//   clk          write clock
//   we/waddr/wdata  write port, waddr = {line, word}
//   raddr/rdata  combinational read port
module icache_data_ram #(
  parameter int N_LINES        = 16,
  parameter int WORDS_PER_LINE = 4,
  localparam int AW = $clog2(N_LINES * WORDS_PER_LINE)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [N_LINES * WORDS_PER_LINE];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped read-only instruction cache with line refill and invalidate-all
//   clk, reset            clock, synchronous active-high reset
//   icache_req/addr       fetch request from core (sampled in IDLE)
//   icache_rdata/ready    fetched word with single-cycle completion pulse
//   inv_all               clear all valid bits
//   mem_req/addr/rdata/valid  single-beat backing read port
//   stat_hits/stat_misses hit/miss counters, present only with ICACHE_STATS_EN
module icache_dm
  import core_pkg::*;
#(
  parameter int ADDR_WIDTH     = 24,
  parameter int N_LINES        = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           icache_addr,
  input  logic                  icache_req,
  output logic [31:0]           icache_rdata,
  output logic                  icache_ready,
  input  logic                  inv_all,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_valid
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]           stat_hits,
  output logic [31:0]           stat_misses
`endif
);
  localparam int OFF_W = off_w(WORDS_PER_LINE);
  localparam int IDX_W = idx_w(N_LINES);
  localparam int TAG_W = tag_w(ADDR_WIDTH, N_LINES, WORDS_PER_LINE);
  localparam int WB    = OFF_W - 2;

  icache_state_t          state;
  logic [ADDR_WIDTH-1:2]  addr_q;
  logic [WB-1:0]          beat;
  logic [N_LINES-1:0]     valid;
  logic [TAG_W-1:0]       tags [N_LINES];
  logic [31:0]            word_q;
  logic                   inv_pend;
  logic [31:0]            ram_rdata;
  logic                   unused_bits;

  wire [TAG_W-1:0] tag_q  = addr_q[ADDR_WIDTH-1 -: TAG_W];
  wire [IDX_W-1:0] idx    = addr_q[OFF_W +: IDX_W];
  wire [WB-1:0]    wsel   = addr_q[2 +: WB];
  wire             hit    = valid[idx] && tags[idx] == tag_q;
  wire             fill   = state == REFILL && mem_req && mem_valid;
  wire             last   = &beat;

  assign unused_bits = ^{icache_addr[31:ADDR_WIDTH], icache_addr[1:0]};

  icache_data_ram #(.N_LINES(N_LINES), .WORDS_PER_LINE(WORDS_PER_LINE)) u_ram (
    .clk   (clk),
    .we    (fill),
    .waddr ({idx, beat}),
    .wdata (mem_rdata),
    .raddr ({idx, wsel}),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk)
    if (fill && last) tags[idx] <= tag_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      addr_q       <= '0;
      beat         <= '0;
      valid        <= '0;
      word_q       <= '0;
      inv_pend     <= 1'b0;
      icache_ready <= 1'b0;
      icache_rdata <= '0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
    end else begin
      icache_ready <= 1'b0;
      if (inv_all) valid <= '0;
      case (state)
        IDLE:
          if (icache_req) begin
            addr_q <= icache_addr[ADDR_WIDTH-1:2];
            state  <= LOOKUP;
          end
        LOOKUP:
          if (hit) begin
            icache_ready <= 1'b1;
            icache_rdata <= ram_rdata;
            state        <= IDLE;
          end else begin
            // the line is being overwritten, so it must not hit on its old tag meanwhile
            valid[idx] <= 1'b0;
            beat       <= '0;
            inv_pend   <= 1'b0;
            mem_addr   <= {addr_q[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
            state      <= REFILL;
          end
        REFILL: begin
          // an invalidate seen at any point of the refill keeps the new line invalid
          inv_pend <= inv_pend | inv_all;
          if (!mem_req) mem_req <= 1'b1;
          else if (mem_valid) begin
            beat <= beat + 1'b1;
            if (beat == wsel) word_q <= mem_rdata;
            if (last) begin
              mem_req      <= 1'b0;
              icache_ready <= 1'b1;
              icache_rdata <= beat == wsel ? mem_rdata : word_q;
              state        <= RESPOND;
              if (!inv_pend && !inv_all) valid[idx] <= 1'b1;
            end else
              mem_addr <= mem_addr + ADDR_WIDTH'(4);
          end
        end
        RESPOND: state <= IDLE;
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (state == LOOKUP) begin
      if (hit) stat_hits <= stat_hits + 1'b1;
      else stat_misses <= stat_misses + 1'b1;
    end
  end
`endif
endmodule
